cpu_memory_arbiter: RTL and testbench
=====================================

CPU_MEMORY_ARBITER -- requirements
Module: cpu_memory_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, blitter wait cycles before promotion above CPU (range 1..15).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 ld_req, ld_write  in  1 each  loader (host ROM load) request; 1 = write, 0 = read.
REQ-005 ld_addr  in  12; ld_wdata  in  8  loader address and write data.
REQ-006 ld_lock  in  1  loader holds memory exclusively against the CPU while high.
REQ-007 cpu_req, cpu_write  in  1 each; cpu_addr  in  12; cpu_wdata  in  8  CPU port.
REQ-008 blt_req, blt_write  in  1 each; blt_addr  in  12; blt_wdata  in  8  sprite blitter port.
REQ-009 ld_gnt, cpu_gnt, blt_gnt  out  1 each  request accepted this cycle.
REQ-010 ld_rvalid, cpu_rvalid, blt_rvalid  out  1 each  read data valid on rdata this cycle.
REQ-011 rdata  out  8  shared read data, direct copy of mem_rdata.
REQ-012 cpu_stall  out  1  high while ld_lock is high.
REQ-013 mem_en, mem_write  out  1 each; mem_addr  out  12; mem_wdata  out  8  registered memory port A drive.
REQ-014 mem_rdata  in  8  memory port A read data, valid the cycle after mem_en with mem_write low.

Function
REQ-015 Arbitration is combinational in cycle N; at most one gnt is high per cycle.
REQ-016 Base priority: loader > CPU > blitter.
REQ-017 ld_lock high: CPU is never granted, whatever cpu_req does.
REQ-018 Starvation counter (4 bits): blt_req high and blt_gnt low -> increment, saturating at 15; blt_gnt high or blt_req low -> clear to 0.
REQ-019 Counter >= STARVE_LIMIT: blitter is placed above the CPU, still below the loader.
REQ-020 Grant in cycle N -> mem_en=1, mem_write/addr/wdata of the winner are registered and driven in cycle N+1.
REQ-021 No grant in cycle N -> mem_en=0 in N+1; mem_write=0; mem_addr/mem_wdata hold their previous values.
REQ-022 Read granted in N -> a 2-bit owner tag is pipelined; the matching *_rvalid is high for exactly one cycle, N+2, with rdata=mem_rdata.
REQ-023 Write granted in N -> no rvalid is ever generated for it.
REQ-024 Handshake: requester holds req and its fields stable until it sees gnt; in the gnt cycle it may drop req or present the next request for cycle N+1. Throughput is one access per cycle.
REQ-025 req dropped before grant is legal; no access is issued for it.
REQ-026 Write-protection of 0x000-0x1FF is enforced by the memory; the arbiter forwards all addresses unchanged.
REQ-027 cpu_stall = ld_lock, combinational.
REQ-028 ld_lock asserted while a CPU read is in flight: that read still completes with cpu_rvalid in N+2.

Reset
REQ-029 While rst_n is low: mem_en, mem_write, all rvalid = 0; mem_addr, mem_wdata = 0; starvation counter = 0; owner tag pipeline cleared.
REQ-030 Reset mid-operation drops any in-flight read; no rvalid appears after rst_n rises for an access granted before reset.
REQ-031 gnt outputs are combinational and follow the req inputs during reset; requesters ignore gnt while rst_n is low. The first grant can occur in the first cycle with rst_n high.

Structure
REQ-032 Package chip8_mem_pkg holds the owner encodings (NONE=0, LD=1, CPU=2, BLT=3), ADDR_W=12, DATA_W=8, and the starvation counter width.
REQ-033 One combinational sub-module, cpu_memory_arb_sel, takes the three reqs, ld_lock and the promote flag, and returns a one-hot grant. All registers stay in cpu_memory_arbiter.

Verification
REQ-034 CPU read only, cpu_addr=0x200 (memory holds 0xA2) -> cpu_gnt in N, mem_en/mem_addr=0x200 in N+1, cpu_rvalid=1 with rdata=0xA2 in N+2.
REQ-035 All three request at once, ld_write=1, ld_addr=0x300, ld_wdata=0x55 -> ld_gnt only; memory write 0x55 at 0x300 in N+1; no rvalid.
REQ-036 STARVE_LIMIT=4, cpu_req and blt_req held continuously -> cpu_gnt in cycles 0-3, blt_gnt in cycle 4, counter 0 in cycle 5, CPU granted again.
REQ-037 ld_lock=1 with a back-to-back loader write stream to 0x200-0x20F and cpu_req held -> cpu_stall=1, no cpu_gnt; the first cpu_gnt comes in the cycle ld_lock falls with ld_req low.
REQ-038 CPU read granted at N, rst_n low in N+1 -> mem_en=0, no cpu_rvalid in N+2 or later; after release a new read at 0x000 returns the font byte with correct timing.
REQ-039 Blitter read at 0x1FF with a CPU write to 0x200 granted the next cycle -> blt_rvalid in N+2, cpu_rvalid never high.

Source files
------------

// File: rtl/chip8_mem_pkg.sv
// Shared encodings and widths for the CHIP-8 memory arbiter slice.
// Owner tags, grant bit positions and the memory command payload.
package chip8_mem_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned OWNER_W  = 2;

  localparam logic [OWNER_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWNER_W-1:0] OWN_LD   = 2'd1;
  localparam logic [OWNER_W-1:0] OWN_CPU  = 2'd2;
  localparam logic [OWNER_W-1:0] OWN_BLT  = 2'd3;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_LD  = 0;
  localparam int unsigned GNT_CPU = 1;
  localparam int unsigned GNT_BLT = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/cpu_memory_arb_sel.sv
// Combinational priority select: loader > (promoted blitter) > CPU > blitter.
// The CPU is masked out entirely while the loader holds the lock.
module cpu_memory_arb_sel
  import chip8_mem_pkg::*;
(
  input  logic       ld_req,
  input  logic       cpu_req,
  input  logic       blt_req,
  input  logic       ld_lock,
  input  logic       promote,
  output logic [2:0] gnt_c
);

  always_comb begin
    gnt_c = '0;
    if (ld_req) begin
      gnt_c[GNT_LD] = 1'b1;
    end else if (promote && blt_req) begin
      gnt_c[GNT_BLT] = 1'b1;
    end else if (cpu_req && !ld_lock) begin
      gnt_c[GNT_CPU] = 1'b1;
    end else if (blt_req) begin
      gnt_c[GNT_BLT] = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_memory_arbiter.sv
// Three-port arbiter (loader, CPU, sprite blitter) in front of a single
// synchronous memory port, with blitter anti-starvation and read-return tagging.
module cpu_memory_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic        ld_write,
  input  logic [11:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_lock,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        blt_req,
  input  logic        blt_write,
  input  logic [11:0] blt_addr,
  input  logic [7:0]  blt_wdata,
  output logic        ld_gnt,
  output logic        cpu_gnt,
  output logic        blt_gnt,
  output logic        ld_rvalid,
  output logic        cpu_rvalid,
  output logic        blt_rvalid,
  output logic [7:0]  rdata,
  output logic        cpu_stall,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  logic [2:0]          gnt_c;
  logic                promote_c;
  mem_cmd_t            win_c;
  logic [OWNER_W-1:0]  win_own_c;

  logic                mem_en_q,    mem_en_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [OWNER_W-1:0]  rd_tag_q,    rd_tag_d;
  logic [2:0]          rvalid_q,    rvalid_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  assign promote_c = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));

  cpu_memory_arb_sel u_sel (
    .ld_req  (ld_req),
    .cpu_req (cpu_req),
    .blt_req (blt_req),
    .ld_lock (ld_lock),
    .promote (promote_c),
    .gnt_c   (gnt_c)
  );

  // Winner's command; with no grant the address/data hold and the write strobe drops
  always_comb begin
    win_c     = '{wr: 1'b0, addr: mem_addr_q, wdata: mem_wdata_q};
    win_own_c = OWN_NONE;
    if (gnt_c[GNT_LD]) begin
      win_c     = '{wr: ld_write, addr: ld_addr, wdata: ld_wdata};
      win_own_c = OWN_LD;
    end else if (gnt_c[GNT_CPU]) begin
      win_c     = '{wr: cpu_write, addr: cpu_addr, wdata: cpu_wdata};
      win_own_c = OWN_CPU;
    end else if (gnt_c[GNT_BLT]) begin
      win_c     = '{wr: blt_write, addr: blt_addr, wdata: blt_wdata};
      win_own_c = OWN_BLT;
    end
  end

  // Next-state: memory drive, owner tag pipeline, rvalid decode, starvation count
  always_comb begin
    mem_en_d     = (win_own_c != OWN_NONE);
    mem_write_d  = win_c.wr;
    mem_addr_d   = win_c.addr;
    mem_wdata_d  = win_c.wdata;
    rd_tag_d     = (mem_en_d && !win_c.wr) ? win_own_c : OWN_NONE;
    rvalid_d     = '0;
    starve_cnt_d = '0;

    case (rd_tag_q)
      OWN_LD:  rvalid_d[GNT_LD]  = 1'b1;
      OWN_CPU: rvalid_d[GNT_CPU] = 1'b1;
      OWN_BLT: rvalid_d[GNT_BLT] = 1'b1;
      default: rvalid_d          = '0;
    endcase

    if (blt_req && !gnt_c[GNT_BLT]) begin
      starve_cnt_d = (starve_cnt_q == {STARVE_W{1'b1}}) ? starve_cnt_q
                                                        : starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q     <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_tag_q     <= OWN_NONE;
      rvalid_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_tag_q     <= rd_tag_d;
      rvalid_q     <= rvalid_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign ld_gnt     = gnt_c[GNT_LD];
  assign cpu_gnt    = gnt_c[GNT_CPU];
  assign blt_gnt    = gnt_c[GNT_BLT];
  assign ld_rvalid  = rvalid_q[GNT_LD];
  assign cpu_rvalid = rvalid_q[GNT_CPU];
  assign blt_rvalid = rvalid_q[GNT_BLT];
  assign rdata      = mem_rdata;
  assign cpu_stall  = ld_lock;
  assign mem_en     = mem_en_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Bench for cpu_memory_arbiter: memory model, arbitration reference model with a
// read-return scoreboard, plus directed scenario tasks with inline checks.
module tb_cpu_memory_arbiter;

  localparam int SL = 4;

  logic        clk;
  logic        rst_n;
  logic        ld_req, ld_write, ld_lock;
  logic [11:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        cpu_req, cpu_write;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        blt_req, blt_write;
  logic [11:0] blt_addr;
  logic [7:0]  blt_wdata;
  logic        ld_gnt, cpu_gnt, blt_gnt;
  logic        ld_rvalid, cpu_rvalid, blt_rvalid;
  logic [7:0]  rdata;
  logic        cpu_stall;
  logic        mem_en, mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  cpu_memory_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_write(ld_write), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .blt_req(blt_req), .blt_write(blt_write), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .ld_gnt(ld_gnt), .cpu_gnt(cpu_gnt), .blt_gnt(blt_gnt),
    .ld_rvalid(ld_rvalid), .cpu_rvalid(cpu_rvalid), .blt_rvalid(blt_rvalid),
    .rdata(rdata), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         owner;
    logic [7:0] data;
    int         due;
  } rd_exp_t;
  rd_exp_t sb[$];

  int          m_cnt;
  logic        e_en, e_wr;
  logic [11:0] e_addr;
  logic [7:0]  e_wd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: reads return next cycle, low 512 bytes are write-protected
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) begin
        if (mem_addr >= 12'h200) mem[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Reference model and read-return scoreboard, evaluated mid-cycle
  initial begin
    m_cnt = 0; e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        m_cnt = 0; e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        total++;
        if ({mem_en, mem_write, ld_rvalid, cpu_rvalid, blt_rvalid} !== 5'b0 ||
            mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
          bad++;
          $display("FAIL mon_reset en=%b wr=%b rv=%b%b%b addr=%h wd=%h exp all zero",
                   mem_en, mem_write, ld_rvalid, cpu_rvalid, blt_rvalid, mem_addr, mem_wdata);
        end
      end else begin
        logic [2:0]  eg;
        logic [2:0]  erv;
        logic [7:0]  edata;
        logic        wr;
        logic [11:0] a;
        logic [7:0]  wd;
        int          own;

        total++;
        if (mem_en !== e_en || mem_write !== e_wr || mem_addr !== e_addr || mem_wdata !== e_wd) begin
          bad++;
          $display("FAIL mon_mem_port cyc=%0d got en=%b wr=%b a=%h d=%h exp en=%b wr=%b a=%h d=%h",
                   cyc, mem_en, mem_write, mem_addr, mem_wdata, e_en, e_wr, e_addr, e_wd);
        end

        erv = 3'b000; edata = 8'h00;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          erv = 3'b001 << (sb[0].owner - 1);
          edata = sb[0].data;
          void'(sb.pop_front());
        end
        total++;
        if ({blt_rvalid, cpu_rvalid, ld_rvalid} !== erv ||
            (erv != 3'b000 && rdata !== edata)) begin
          bad++;
          $display("FAIL mon_rvalid cyc=%0d got rv(blt,cpu,ld)=%b rdata=%h exp rv=%b rdata=%h",
                   cyc, {blt_rvalid, cpu_rvalid, ld_rvalid}, rdata, erv, edata);
        end

        eg = 3'b000;
        if (ld_req) eg = 3'b001;
        else if (m_cnt >= SL && blt_req) eg = 3'b100;
        else if (cpu_req && !ld_lock) eg = 3'b010;
        else if (blt_req) eg = 3'b100;
        total++;
        if ({blt_gnt, cpu_gnt, ld_gnt} !== eg || cpu_stall !== ld_lock) begin
          bad++;
          $display("FAIL mon_grant cyc=%0d got gnt(blt,cpu,ld)=%b stall=%b exp gnt=%b stall=%b",
                   cyc, {blt_gnt, cpu_gnt, ld_gnt}, cpu_stall, eg, ld_lock);
        end

        wr = 1'b0; a = e_addr; wd = e_wd; own = 0;
        if (eg[0]) begin wr = ld_write;  a = ld_addr;  wd = ld_wdata;  own = 1; end
        if (eg[1]) begin wr = cpu_write; a = cpu_addr; wd = cpu_wdata; own = 2; end
        if (eg[2]) begin wr = blt_write; a = blt_addr; wd = blt_wdata; own = 3; end
        e_en = (own != 0); e_wr = wr; e_addr = a; e_wd = wd;
        if (own != 0) begin
          if (wr) begin
            if (a >= 12'h200) ref_mem[a] = wd;
          end else begin
            sb.push_back('{owner: own, data: ref_mem[a], due: cyc + 2});
          end
        end
        m_cnt = (blt_req && !eg[2]) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 12'h000 ||
        {ld_rvalid, cpu_rvalid, blt_rvalid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_state en=%b wr=%b addr=%h rv=%b exp 0/0/000/000",
               mem_en, mem_write, mem_addr, {ld_rvalid, cpu_rvalid, blt_rvalid});
    end
    next_cycle();
    cpu_req = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL reset_gnt_follows_req got=%b exp=1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h200;
    @(negedge clk);
    total++;
    if ({blt_gnt, cpu_gnt, ld_gnt} !== 3'b010) begin
      bad++;
      $display("FAIL cpu_read_gnt got=%b exp=010", {blt_gnt, cpu_gnt, ld_gnt});
    end
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 12'h200) begin
      bad++;
      $display("FAIL cpu_read_port got en=%b wr=%b a=%h exp 1/0/200", mem_en, mem_write, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'hA2) begin
      bad++;
      $display("FAIL cpu_read_data got rv=%b d=%h exp 1/a2", cpu_rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_all_three();
    ld_req = 1'b1; ld_write = 1'b1; ld_addr = 12'h300; ld_wdata = 8'h55;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h010;
    blt_req = 1'b1; blt_write = 1'b0; blt_addr = 12'h020;
    @(negedge clk);
    total++;
    if ({blt_gnt, cpu_gnt, ld_gnt} !== 3'b001) begin
      bad++;
      $display("FAIL all3_gnt got=%b exp=001", {blt_gnt, cpu_gnt, ld_gnt});
    end
    next_cycle();
    ld_req = 1'b0; cpu_req = 1'b0; blt_req = 1'b0; ld_write = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 12'h300 || mem_wdata !== 8'h55) begin
      bad++;
      $display("FAIL all3_port got en=%b wr=%b a=%h d=%h exp 1/1/300/55",
               mem_en, mem_write, mem_addr, mem_wdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({ld_rvalid, cpu_rvalid, blt_rvalid} !== 3'b000) begin
      bad++;
      $display("FAIL all3_no_rvalid got=%b exp=000", {ld_rvalid, cpu_rvalid, blt_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h040;
    blt_req = 1'b1; blt_write = 1'b0; blt_addr = 12'h1FF;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] exp_g;
      exp_g = (i == 4 || i == 9) ? 3'b100 : 3'b010;
      @(negedge clk);
      total++;
      if ({blt_gnt, cpu_gnt, ld_gnt} !== exp_g) begin
        bad++;
        $display("FAIL starve_cycle%0d got=%b exp=%b", i, {blt_gnt, cpu_gnt, ld_gnt}, exp_g);
      end
      next_cycle();
    end
    cpu_req = 1'b0; blt_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_ld_lock();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h005;
    next_cycle();
    cpu_addr = 12'h006;
    ld_lock = 1'b1; ld_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_req = 1'b1; ld_addr = 12'h200 + 12'(i); ld_wdata = 8'h80 + 8'(i);
      @(negedge clk);
      total++;
      if (ld_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
        bad++;
        $display("FAIL lock_stream%0d got ld=%b cpu=%b stall=%b exp 1/0/1", i, ld_gnt, cpu_gnt, cpu_stall);
      end
      if (i == 1) begin
        total++;
        if (cpu_rvalid !== 1'b1 || rdata !== 8'h5F) begin
          bad++;
          $display("FAIL lock_inflight_read got rv=%b d=%h exp 1/5f", cpu_rvalid, rdata);
        end
      end
      next_cycle();
    end
    ld_req = 1'b0; ld_write = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      bad++;
      $display("FAIL lock_idle got cpu=%b stall=%b exp 0/1", cpu_gnt, cpu_stall);
    end
    next_cycle();
    ld_lock = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL lock_release got cpu=%b stall=%b exp 1/0", cpu_gnt, cpu_stall);
    end
    next_cycle();
    cpu_addr = 12'h20A;
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'h8A) begin
      bad++;
      $display("FAIL lock_readback got rv=%b d=%h exp 1/8a", cpu_rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h210;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rst_inflight_gnt got=%b exp=1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || cpu_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_inflight_clear got en=%b rv=%b exp 0/0", mem_en, cpu_rvalid);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rst_inflight_ghost%0d got=%b exp=0", i, cpu_rvalid);
      end
      next_cycle();
    end
    cpu_req = 1'b1; cpu_addr = 12'h000;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rst_font_gnt got=%b exp=1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h000) begin
      bad++;
      $display("FAIL rst_font_port got en=%b a=%h exp 1/000", mem_en, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'hF0) begin
      bad++;
      $display("FAIL rst_font_data got rv=%b d=%h exp 1/f0", cpu_rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    blt_req = 1'b1; blt_write = 1'b0; blt_addr = 12'h1FF;
    @(negedge clk);
    total++;
    if (blt_gnt !== 1'b1) begin
      bad++;
      $display("FAIL b2b_blt_gnt got=%b exp=1", blt_gnt);
    end
    next_cycle();
    blt_req = 1'b0;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h77;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL b2b_cpu_gnt got=%b exp=1", cpu_gnt);
    end
    next_cycle();
    cpu_req = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    total++;
    if (blt_rvalid !== 1'b1 || rdata !== 8'h3C || cpu_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_blt_data got brv=%b crv=%b d=%h exp 1/0/3c", blt_rvalid, cpu_rvalid, rdata);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_no_cpu_rvalid%0d got=%b exp=0", i, cpu_rvalid);
      end
      next_cycle();
    end
  endtask

  // Randomised traffic obeying the hold-until-grant handshake; model checks every cycle
  task automatic test_random();
    logic gl, gc, gb;
    gl = 1'b0; gc = 1'b0; gb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ld_req || gl) begin
        ld_req = ($urandom_range(0, 3) == 0);
        ld_write = 1'($urandom_range(0, 1));
        ld_addr = 12'($urandom_range(0, 4095));
        ld_wdata = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 15) == 0) begin
        ld_req = 1'b0;
      end
      if (!cpu_req || gc) begin
        cpu_req = ($urandom_range(0, 1) == 0);
        cpu_write = 1'($urandom_range(0, 1));
        cpu_addr = 12'($urandom_range(0, 4095));
        cpu_wdata = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 15) == 0) begin
        cpu_req = 1'b0;
      end
      if (!blt_req || gb) begin
        blt_req = ($urandom_range(0, 1) == 0);
        blt_write = 1'($urandom_range(0, 1));
        blt_addr = 12'($urandom_range(0, 4095));
        blt_wdata = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 9) == 0) ld_lock = ~ld_lock;
      @(negedge clk);
      gl = ld_gnt; gc = cpu_gnt; gb = blt_gnt;
      total++;
      if ($countones({gl, gc, gb}) > 1) begin
        bad++;
        $display("FAIL rand_onehot%0d got gnt=%b exp at most one", i, {gl, gc, gb});
      end
      next_cycle();
    end
    ld_req = 1'b0; cpu_req = 1'b0; blt_req = 1'b0; ld_lock = 1'b0;
    repeat (4) next_cycle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rand_drain got pending=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ld_req = 0; ld_write = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
    cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    blt_req = 0; blt_write = 0; blt_addr = '0; blt_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h000] = 8'hF0;
    mem[12'h1FF] = 8'h3C;
    mem[12'h200] = 8'hA2;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    test_reset();
    next_cycle();
    test_cpu_read();
    test_all_three();
    test_starvation();
    test_ld_lock();
    test_reset_inflight();
    test_back_to_back();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
